// File: rtl/ahb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_sram_arbiter
//
// Shares one single-port synchronous SRAM bank (4096 x 32) between two
// AHB-Lite masters: the instruction-fetch bus (imem) and the load/store bus
// (dmem). Each master's address phase is captured into a slot. At most one
// RAM access is issued per cycle, and ties are broken round-robin. A master
// whose slot is waiting for the RAM is stalled with hready low.
//
// Ports
//   clk, reset_n               clock (rising edge), async active-low reset
//   imem_h* / dmem_h* (in)     AHB-Lite master request: haddr, htrans,
//                              hwrite, hsize, hwdata
//   imem_h* / dmem_h* (out)    AHB-Lite response: hrdata, hready, hresp
//   ram_en, ram_rwn            RAM strobe, 1 = read / 0 = write
//   ram_addr, ram_wben         RAM word address (haddr[13:2]), byte enables
//   ram_wdata, ram_rdata       RAM write data, read data (one cycle later)
//   conflict_cnt               saturating count of both-slots-waiting cycles
// ---------------------------------------------------------------------------
module ahb_sram_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] imem_haddr,
    input  logic [1:0]  imem_htrans,
    input  logic        imem_hwrite,
    input  logic [2:0]  imem_hsize,
    input  logic [31:0] imem_hwdata,
    output logic [31:0] imem_hrdata,
    output logic        imem_hready,
    output logic        imem_hresp,

    input  logic [31:0] dmem_haddr,
    input  logic [1:0]  dmem_htrans,
    input  logic        dmem_hwrite,
    input  logic [2:0]  dmem_hsize,
    input  logic [31:0] dmem_hwdata,
    output logic [31:0] dmem_hrdata,
    output logic        dmem_hready,
    output logic        dmem_hresp,

    output logic        ram_en,
    output logic        ram_rwn,
    output logic [11:0] ram_addr,
    output logic [3:0]  ram_wben,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,

    output logic [15:0] conflict_cnt
);

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_WAIT  = 2'b01,
        SLOT_RESP  = 2'b10
    } slot_state_e;

    // Index 0 is imem, index 1 is dmem; last_q holds the index of the
    // master that was granted most recently.
    localparam logic MST_DMEM = 1'b1;

    // Byte write enables from transfer size and the low address bits.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Per-master views of the request ports so both slots share one code path.
    logic [1:0]  htrans_s [2];
    logic [31:0] haddr_s  [2];
    logic        hwrite_s [2];
    logic [2:0]  hsize_s  [2];
    logic [31:0] hwdata_s [2];

    assign htrans_s[0] = imem_htrans;
    assign htrans_s[1] = dmem_htrans;
    assign haddr_s[0]  = imem_haddr;
    assign haddr_s[1]  = dmem_haddr;
    assign hwrite_s[0] = imem_hwrite;
    assign hwrite_s[1] = dmem_hwrite;
    assign hsize_s[0]  = imem_hsize;
    assign hsize_s[1]  = dmem_hsize;
    assign hwdata_s[0] = imem_hwdata;
    assign hwdata_s[1] = dmem_hwdata;

    // Upper address bits are decoded upstream; htrans[0] only separates
    // NONSEQ from SEQ (and IDLE from BUSY), which is irrelevant here.
    logic unused_s;
    assign unused_s = ^{imem_haddr[31:14], imem_htrans[0],
                        dmem_haddr[31:14], dmem_htrans[0]};

    slot_state_e state_q [2];
    slot_state_e state_d [2];
    logic [13:0] addr_q  [2];
    logic [13:0] addr_d  [2];
    logic        write_q [2];
    logic        write_d [2];
    logic [2:0]  size_q  [2];
    logic [2:0]  size_d  [2];

    logic        last_q;
    logic        last_d;
    logic [15:0] conflict_q;
    logic [15:0] conflict_d;
    logic [11:0] ram_addr_q;
    logic [31:0] ram_wdata_q;

    logic [1:0]  wait_s;
    logic [1:0]  gnt_s;
    logic [1:0]  hready_s;
    logic [1:0]  cap_s;
    logic        sel_s;

    // Grant: only WAIT slots compete; on a tie the master that was not
    // granted last time wins.
    always_comb begin
        wait_s[0] = (state_q[0] == SLOT_WAIT);
        wait_s[1] = (state_q[1] == SLOT_WAIT);
        gnt_s     = 2'b00;
        case (wait_s)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = (last_q == MST_DMEM) ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
        sel_s = gnt_s[1];
    end

    // Per-master hready and address-phase capture. A granted write finishes
    // in its access cycle, so hready is high then; a granted read is
    // answered in the following RESP cycle.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            hready_s[m] = 1'b1;
            case (state_q[m])
                SLOT_EMPTY: hready_s[m] = 1'b1;
                SLOT_WAIT:  hready_s[m] = gnt_s[m] & write_q[m];
                SLOT_RESP:  hready_s[m] = 1'b1;
                default:    hready_s[m] = 1'b1;
            endcase
            cap_s[m] = htrans_s[m][1] & hready_s[m];
        end
    end

    // RAM port drive. Address and write data hold their previous value
    // while the RAM is idle.
    always_comb begin
        ram_en    = 1'b0;
        ram_rwn   = 1'b1;
        ram_wben  = 4'b0000;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        if (gnt_s != 2'b00) begin
            ram_en   = 1'b1;
            ram_addr = addr_q[sel_s][13:2];
            if (write_q[sel_s]) begin
                ram_rwn   = 1'b0;
                ram_wben  = byte_en(size_q[sel_s], addr_q[sel_s][1:0]);
                ram_wdata = hwdata_s[sel_s];
            end else begin
                ram_rwn   = 1'b1;
                ram_wben  = 4'b0000;
                ram_wdata = ram_wdata_q;
            end
        end else begin
            ram_en    = 1'b0;
            ram_rwn   = 1'b1;
            ram_wben  = 4'b0000;
            ram_addr  = ram_addr_q;
            ram_wdata = ram_wdata_q;
        end
    end

    // Slot next-state. Capture is only possible while hready is high, so a
    // stalled WAIT slot or a granted read never re-captures.
    always_comb begin
        for (int m = 0; m < 2; m++) begin
            state_d[m] = state_q[m];
            addr_d[m]  = addr_q[m];
            write_d[m] = write_q[m];
            size_d[m]  = size_q[m];
            case (state_q[m])
                SLOT_EMPTY: state_d[m] = cap_s[m] ? SLOT_WAIT : SLOT_EMPTY;
                SLOT_WAIT: begin
                    if (gnt_s[m]) begin
                        if (write_q[m]) begin
                            state_d[m] = cap_s[m] ? SLOT_WAIT : SLOT_EMPTY;
                        end else begin
                            state_d[m] = SLOT_RESP;
                        end
                    end else begin
                        state_d[m] = SLOT_WAIT;
                    end
                end
                SLOT_RESP:  state_d[m] = cap_s[m] ? SLOT_WAIT : SLOT_EMPTY;
                default:    state_d[m] = SLOT_EMPTY;
            endcase
            if (cap_s[m]) begin
                addr_d[m]  = haddr_s[m][13:0];
                write_d[m] = hwrite_s[m];
                size_d[m]  = hsize_s[m];
            end else begin
                addr_d[m]  = addr_q[m];
                write_d[m] = write_q[m];
                size_d[m]  = size_q[m];
            end
        end
    end

    // Round-robin pointer and saturating conflict counter next-state.
    always_comb begin
        if (gnt_s != 2'b00) begin
            last_d = sel_s;
        end else begin
            last_d = last_q;
        end
        if ((wait_s == 2'b11) && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State registers; reset drops any pending transfer immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= SLOT_EMPTY;
                addr_q[m]  <= 14'd0;
                write_q[m] <= 1'b0;
                size_q[m]  <= 3'd0;
            end
            last_q      <= MST_DMEM;
            conflict_q  <= 16'd0;
            ram_addr_q  <= 12'd0;
            ram_wdata_q <= 32'd0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                state_q[m] <= state_d[m];
                addr_q[m]  <= addr_d[m];
                write_q[m] <= write_d[m];
                size_q[m]  <= size_d[m];
            end
            last_q      <= last_d;
            conflict_q  <= conflict_d;
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
        end
    end

    assign imem_hready  = hready_s[0];
    assign dmem_hready  = hready_s[1];
    assign imem_hrdata  = (state_q[0] == SLOT_RESP) ? ram_rdata : 32'd0;
    assign dmem_hrdata  = (state_q[1] == SLOT_RESP) ? ram_rdata : 32'd0;
    assign imem_hresp   = 1'b0;
    assign dmem_hresp   = 1'b0;
    assign conflict_cnt = conflict_q;

endmodule

// File: doc/ahb_sram_arbiter.md
# ahb_sram_arbiter

Two-master AHB-Lite arbiter that shares one single-port synchronous SRAM bank (4096 x 32) between the RISC-V core's instruction-fetch bus (imem) and load/store bus (dmem). It captures each master's address phase, performs at most one RAM access per cycle with round-robin tie-breaking, and stalls the losing master with HREADY low. It sits between the core's AHB ports and one RAM macro. The address decoder selects the RAM region upstream.

## Interface
- No parameters. RAM depth is fixed at 4096 words and RAM address is `haddr[13:2]`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `imem_haddr` in 32, `imem_htrans` in 2, `imem_hwrite` in 1, `imem_hsize` in 3, `imem_hwdata` in 32: instruction-bus master request.
- `imem_hrdata` out 32, `imem_hready` out 1, `imem_hresp` out 1: instruction-bus response.
- `dmem_haddr`, `dmem_htrans`, `dmem_hwrite`, `dmem_hsize`, `dmem_hwdata`, `dmem_hrdata`, `dmem_hready`, `dmem_hresp`: same widths and meanings as the imem signals, for the data bus.
- `ram_en` out 1: RAM access strobe for the current cycle.
- `ram_rwn` out 1: 1 = read, 0 = write.
- `ram_addr` out 12: RAM word address.
- `ram_wben` out 4: byte write enables.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid in the cycle after a read access.
- `conflict_cnt` out 16: saturating count of cycles in which both slots waited for the RAM.

## Operation
- **Slots.** Each master has a slot holding {addr, write, size} plus `valid` and `phase` (WAIT or RESP).
  - A slot is captured on a rising edge when `htrans[1]`=1 (NONSEQ or SEQ) and that master's `hready`=1.
  - IDLE and BUSY transfers are ignored.
- **Slot FSM.**
  - EMPTY -> WAIT on capture.
  - WAIT -> (access cycle) -> write: EMPTY, or re-capture if a new request is present; read: RESP.
  - RESP -> EMPTY, or WAIT if a new request is captured at the same edge.
- **Grant (combinational, per cycle).**
  - Only WAIT slots are eligible. A RESP slot is not eligible.
  - One eligible slot: it is granted.
  - Both eligible: the master other than `last` is granted.
  - `last` updates to the granted master on every access. Its reset value is dmem, so imem wins the first tie.
- **Access cycle of a granted slot.**
  - `ram_en`=1 and `ram_addr`=slot addr[13:2].
  - Write: `ram_rwn`=0, `ram_wdata`=that master's live `hwdata`, `ram_wben` from size and addr (below), master `hready`=1. The write completes this cycle.
  - Read: `ram_rwn`=1, `ram_wben`=0, master `hready`=0.
- **RESP cycle.**
  - Master `hready`=1 and `hrdata`=`ram_rdata` (combinational pass-through).
  - The other slot may be granted the RAM in this same cycle.
- **Stalls.** `hready`=0 in every cycle a slot is in WAIT and not granted. An EMPTY slot drives `hready`=1.
- **Byte enables.**
  - hsize 000: one-hot on addr[1:0].
  - hsize 001: addr[1]=0 -> 0011, else 1100.
  - hsize 010 and above: 1111.
- **Unused outputs.** When `ram_en`=0: `ram_rwn`=1, `ram_wben`=0, and `ram_addr`/`ram_wdata` are don't-care (hold last value). `hrdata` is don't-care when `hready`=0 or the slot is not in RESP.
- **Response code.** `hresp`=0 (OKAY) always.
- **Conflict counter.** `conflict_cnt` increments on each cycle where both slots are in WAIT, and saturates at 0xFFFF.

## Timing
- **Reset** (asynchronous, on `reset_n`=0): slots EMPTY; `imem_hready`=`dmem_hready`=1; `hresp`=0; `hrdata`=0; `ram_en`=0; `ram_rwn`=1; `ram_wben`=0; `ram_addr`=0; `ram_wdata`=0; `last`=dmem; `conflict_cnt`=0. Deassertion takes effect at the next rising edge.
- **Reset mid-transfer:** all pending transfers are dropped. No RAM write is issued after `reset_n` falls.
- **Uncontended latency:**
  - Write: address phase in cycle 0, access and `hready`=1 in cycle 1 (zero wait states).
  - Read: access in cycle 1 with `hready`=0, data and `hready`=1 in cycle 2 (one wait state).
- **Back-to-back reads from one master:** the RAM is busy one cycle out of every two.
- **Contended worst case:** a WAIT slot loses at most once in a row. A read therefore completes within 3 cycles of acceptance, and a write within 2.
- **Simultaneous events:**
  - A RESP for one master and an access for the other occur in the same cycle.
  - Capture of a new address phase at the same edge as a completing write or RESP is legal.

## Test plan
- **Reset state:** with `reset_n` low, check every output equals its reset value. Release `reset_n`, drive no transfers for 5 cycles: `ram_en` stays 0 and both `hready` stay 1.
- **Single imem read:** imem read of 0x0000_0104 -> cycle 1 `ram_en`=1, `ram_addr`=0x041, `imem_hready`=0 -> cycle 2 `imem_hready`=1, `imem_hrdata`=`ram_rdata` (0xDEADBEEF).
- **dmem byte write:** dmem byte write to 0x0000_4006 with data 0x00AB_0000 -> cycle 1 `ram_wben`=0100, `ram_rwn`=0, `dmem_hready`=1. Repeat with a halfword at offset 2 -> `ram_wben`=1100.
- **Simultaneous reads after reset:** both masters read at the same edge -> cycle 1 imem access, cycle 2 dmem access plus imem data, cycle 3 dmem data. `dmem_hready`=0 in cycles 1-2. `conflict_cnt`=1.
- **Round-robin fairness:** both masters issue back-to-back reads for 20 cycles -> RAM grants alternate every cycle, no master waits more than 1 extra cycle, and `conflict_cnt` counts only both-WAIT cycles.
- **Reset during contended write:** assert `reset_n`=0 while a dmem write slot is in WAIT -> no `ram_en` write occurs, both `hready`=1 immediately, `conflict_cnt`=0.
